// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of the shared 8-to-1 mux.
// Optional per-ownership burst limit is compiled in with `define MUX_ARB_BURST_LIMIT_EN.
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic [2:0] owner
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_d;
    logic [2:0] sel_d;
    logic       valid_d;
    logic [2:0] owner_d;
    logic [2:0] win;
    logic       burst_done;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("mux_rr_arbiter: MAX_BURST must be in 1..255");
    end

    // The owner register doubles as the rotation pointer: it always holds the
    // last granted index, which is exactly where the priority scan starts from.
    always_comb begin
        win = owner;
        // Scan downward so the lowest offset from owner+1 is the last to assign.
        for (int i = 8; i >= 1; i--) begin
            if (req[owner + 3'(i)]) begin
                win = owner + 3'(i);
            end
        end
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [7:0] burst_q;

    // Counts completed GRANT edges; cleared while idle, so it starts at 0 on every grant.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_q + 8'd1;
        end
    end

    assign burst_done = (burst_q == 8'(MAX_BURST - 1));
`else
    assign burst_done = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel;
        valid_d = valid;
        owner_d = owner;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win;
                    valid_d = 1'b1;
                    owner_d = win;
                    sel_d   = 3'd7 - win;
                end
            end
            GRANT: begin
                // sel/owner deliberately hold through the dead cycle.
                if (!req[owner] || burst_done) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            sel     <= 3'b000;
            valid   <= 1'b0;
            owner   <= 3'd7;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            valid   <= valid_d;
            owner   <= owner_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; burst expectations follow
// whether MUX_ARB_BURST_LIMIT_EN is defined for the build.
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [7:0] gnt;
        logic       valid;
        logic [2:0] sel;
        logic [2:0] owner;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic [2:0] owner;
    out_t       obs;

    int passed = 0;
    int total  = 0;

    localparam out_t RESET_OUT = '{gnt: 8'h00, valid: 1'b0, sel: 3'b000, owner: 3'd7};

    mux_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .valid(valid),
        .owner(owner)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, valid, sel, owner};

    function automatic out_t grant_of(input int w);
        out_t o;
        o.gnt   = 8'd1 << w;
        o.valid = 1'b1;
        o.sel   = 3'(7 - w);
        o.owner = 3'(w);
        return o;
    endfunction

    function automatic out_t idle_of(input int w);
        out_t o;
        o.gnt   = 8'h00;
        o.valid = 1'b0;
        o.sel   = 3'(7 - w);
        o.owner = 3'(w);
        return o;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_t ex [3];
        ex = '{RESET_OUT, RESET_OUT, grant_of(0)};
        rst = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL reset[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
            if (k == 1) rst = 1'b0;
        end
    endtask

    task automatic test_rotation();
        logic [7:0] rq [9];
        out_t       ex [9];
        rq = '{8'h81, 8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h81, 8'h01, 8'h81};
        ex = '{grant_of(0), grant_of(0), grant_of(0), idle_of(0),
               grant_of(7), grant_of(7), grant_of(7), idle_of(7), grant_of(0)};
        reset_dut();
        for (int k = 0; k < 9; k++) begin
            req = rq[k];
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL rotation[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
        end
    endtask

    task automatic test_no_preempt_wrap();
        logic [7:0] rq [6];
        out_t       ex [6];
        rq = '{8'h80, 8'h89, 8'h89, 8'h09, 8'h09, 8'h09};
        ex = '{grant_of(7), grant_of(7), grant_of(7), idle_of(7), grant_of(0), grant_of(0)};
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            req = rq[k];
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL no_preempt_wrap[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
        end
    endtask

    task automatic test_burst();
        out_t ex [11];
`ifdef MUX_ARB_BURST_LIMIT_EN
        ex = '{grant_of(1), grant_of(1), grant_of(1), grant_of(1), idle_of(1),
               grant_of(2), grant_of(2), grant_of(2), grant_of(2), idle_of(2), grant_of(1)};
`else
        ex = '{grant_of(1), grant_of(1), grant_of(1), grant_of(1), grant_of(1),
               grant_of(1), grant_of(1), grant_of(1), grant_of(1), grant_of(1), grant_of(1)};
`endif
        reset_dut();
        req = 8'h06;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL burst[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
        end
    endtask

    task automatic test_reset_mid_grant();
        logic rs [5];
        out_t ex [5];
        rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ex = '{grant_of(5), grant_of(5), RESET_OUT, grant_of(5), grant_of(5)};
        reset_dut();
        req = 8'h20;
        for (int k = 0; k < 5; k++) begin
            rst = rs[k];
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL reset_mid_grant[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
        end
    endtask

    task automatic test_idle_hold();
        logic [7:0] rq [4];
        out_t       ex [4];
        rq = '{8'h00, 8'h00, 8'h40, 8'h00};
        ex = '{RESET_OUT, RESET_OUT, grant_of(6), idle_of(6)};
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            req = rq[k];
            @(negedge clk);
            total++;
            if (obs !== ex[k])
                $display("FAIL idle_hold[%0d]: got gnt=%h valid=%b sel=%b owner=%0d, expected gnt=%h valid=%b sel=%b owner=%0d",
                         k, obs.gnt, obs.valid, obs.sel, obs.owner, ex[k].gnt, ex[k].valid, ex[k].sel, ex[k].owner);
            else
                passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_rotation();
        test_no_preempt_wrap();
        test_burst();
        test_reset_mid_grant();
        test_idle_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
